// File: rtl/conv_ctrl_pkg.sv
// Shared constants, state encoding and 3x3 tap offset tables for the CONV layer-0/1 sequencer.
package conv_ctrl_pkg;

    localparam int CONV_IMG_LOG2 = 6;
    localparam int CONV_ADDR_W   = 2 * CONV_IMG_LOG2;

    localparam logic [3:0] TAP_LAST  = 4'd8;
    localparam logic [2:0] CSEL_NONE = 3'b000;
    localparam logic [2:0] CSEL_L0   = 3'b001;
    localparam logic [2:0] CSEL_L1   = 3'b011;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONV_TAP,
        S_CONV_WR,
        S_POOL_RD,
        S_POOL_WR,
        S_DONE
    } conv_state_t;

    // Two's-complement row offset (-1, 0, +1) of tap k = k/3 - 1.
    function automatic logic [1:0] tap_dy(input logic [3:0] k);
        case (k)
            4'd0, 4'd1, 4'd2: tap_dy = 2'b11;
            4'd6, 4'd7, 4'd8: tap_dy = 2'b01;
            default:          tap_dy = 2'b00;
        endcase
    endfunction

    // Two's-complement column offset of tap k = k%3 - 1.
    function automatic logic [1:0] tap_dx(input logic [3:0] k);
        case (k)
            4'd0, 4'd3, 4'd6: tap_dx = 2'b11;
            4'd2, 4'd5, 4'd8: tap_dx = 2'b01;
            default:          tap_dx = 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/conv_ctrl_if.sv
// Sequencer-to-datapath bundle: host handshake, image/L0/L1 addressing, MAC and pool strobes.
interface conv_ctrl_if
    import conv_ctrl_pkg::*;
#(
    parameter int ADDR_W = CONV_ADDR_W
);
    logic              ready;
    logic              busy;
    logic [ADDR_W-1:0] iaddr;
    logic [3:0]        tap_k;
    logic              mac_en;
    logic              mac_clr;
    logic              cwr;
    logic [ADDR_W-1:0] caddr_wr;
    logic              crd;
    logic [ADDR_W-1:0] caddr_rd;
    logic              pool_en;
    logic              pool_ld;
    logic [2:0]        csel;

    modport master (
        input  ready,
        output busy, iaddr, tap_k, mac_en, mac_clr, cwr, caddr_wr,
               crd, caddr_rd, pool_en, pool_ld, csel
    );

    modport slave (
        output ready,
        input  busy, iaddr, tap_k, mac_en, mac_clr, cwr, caddr_wr,
               crd, caddr_rd, pool_en, pool_ld, csel
    );
endinterface

// File: rtl/conv_ctrl_tap_addr.sv
// Maps pixel (row, col) and kernel tap to a zero-padded image address plus an in-bounds flag.
module conv_ctrl_tap_addr
    import conv_ctrl_pkg::*;
#(
    parameter int IMG_LOG2 = CONV_IMG_LOG2
)(
    input  logic [IMG_LOG2-1:0]   row,
    input  logic [IMG_LOG2-1:0]   col,
    input  logic [3:0]            tap_k,
    output logic [2*IMG_LOG2-1:0] iaddr,
    output logic                  in_bounds
);
    logic [1:0]          dy;
    logic [1:0]          dx;
    logic [IMG_LOG2+1:0] row_t;
    logic [IMG_LOG2+1:0] col_t;

    // Two guard bits catch both -1 (all ones) and IMG side (carry into bit IMG_LOG2).
    always_comb begin
        dy        = tap_dy(tap_k);
        dx        = tap_dx(tap_k);
        row_t     = {2'b00, row} + {{IMG_LOG2{dy[1]}}, dy};
        col_t     = {2'b00, col} + {{IMG_LOG2{dx[1]}}, dx};
        in_bounds = (row_t[IMG_LOG2+1:IMG_LOG2] == 2'b00) &&
                    (col_t[IMG_LOG2+1:IMG_LOG2] == 2'b00);
        iaddr     = in_bounds ? {row_t[IMG_LOG2-1:0], col_t[IMG_LOG2-1:0]} : '0;
    end

endmodule

// File: rtl/conv_ctrl.sv
// Sequencer for 3x3 conv + ReLU into L0, then 2x2/stride-2 max-pool into L1.
// Outputs are registered copies of values decoded from next state/counters.
module conv_ctrl
    import conv_ctrl_pkg::*;
#(
    parameter int IMG_LOG2 = CONV_IMG_LOG2,
    parameter int ADDR_W   = 2 * IMG_LOG2
)(
    input  logic        clk,
    input  logic        reset,
    conv_ctrl_if.master bus
);
    localparam int PL2 = IMG_LOG2 - 1;

    conv_state_t         state_reg, state_next;
    logic [IMG_LOG2-1:0] row_reg, row_next;
    logic [IMG_LOG2-1:0] col_reg, col_next;
    logic [PL2-1:0]      prow_reg, prow_next;
    logic [PL2-1:0]      pcol_reg, pcol_next;
    logic [3:0]          tap_reg, tap_next;
    logic [1:0]          quad_reg, quad_next;

    logic                busy_reg, busy_next;
    logic [ADDR_W-1:0]   iaddr_reg, iaddr_next;
    logic [3:0]          tap_k_reg, tap_k_next;
    logic                mac_en_reg, mac_en_next;
    logic                mac_clr_reg, mac_clr_next;
    logic                cwr_reg, cwr_next;
    logic [ADDR_W-1:0]   caddr_wr_reg, caddr_wr_next;
    logic                crd_reg, crd_next;
    logic [ADDR_W-1:0]   caddr_rd_reg, caddr_rd_next;
    logic                pool_en_reg, pool_en_next;
    logic                pool_ld_reg, pool_ld_next;
    logic [2:0]          csel_reg, csel_next;

    logic [2*IMG_LOG2-1:0] tap_iaddr;
    logic                  tap_in_bounds;

    // Address generator looks at the upcoming pixel/tap so iaddr can be registered.
    conv_ctrl_tap_addr #(.IMG_LOG2(IMG_LOG2)) u_tap_addr (
        .row       (row_next),
        .col       (col_next),
        .tap_k     (tap_next),
        .iaddr     (tap_iaddr),
        .in_bounds (tap_in_bounds)
    );

    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        col_next   = col_reg;
        prow_next  = prow_reg;
        pcol_next  = pcol_reg;
        tap_next   = tap_reg;
        quad_next  = quad_reg;
        case (state_reg)
            S_IDLE: begin
                if (bus.ready) begin
                    state_next = S_CONV_TAP;
                    row_next   = '0;
                    col_next   = '0;
                    tap_next   = '0;
                end
            end
            S_CONV_TAP: begin
                if (tap_reg == TAP_LAST) begin
                    state_next = S_CONV_WR;
                    tap_next   = '0;
                end else begin
                    tap_next   = tap_reg + 4'd1;
                end
            end
            S_CONV_WR: begin
                // Counters wrap naturally to 0, which is also the first pool block.
                col_next = col_reg + 1'b1;
                if (&col_reg) begin
                    row_next = row_reg + 1'b1;
                end
                if ((&col_reg) && (&row_reg)) begin
                    state_next = S_POOL_RD;
                    prow_next  = '0;
                    pcol_next  = '0;
                    quad_next  = '0;
                end else begin
                    state_next = S_CONV_TAP;
                end
            end
            S_POOL_RD: begin
                quad_next = quad_reg + 2'd1;
                if (quad_reg == 2'd3) begin
                    state_next = S_POOL_WR;
                end
            end
            S_POOL_WR: begin
                pcol_next = pcol_reg + 1'b1;
                if (&pcol_reg) begin
                    prow_next = prow_reg + 1'b1;
                end
                state_next = ((&pcol_reg) && (&prow_reg)) ? S_DONE : S_POOL_RD;
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        busy_next     = (state_next != S_IDLE);
        iaddr_next    = '0;
        tap_k_next    = '0;
        mac_en_next   = 1'b0;
        mac_clr_next  = 1'b0;
        cwr_next      = 1'b0;
        caddr_wr_next = '0;
        crd_next      = 1'b0;
        caddr_rd_next = '0;
        pool_en_next  = 1'b0;
        pool_ld_next  = 1'b0;
        csel_next     = CSEL_NONE;
        case (state_next)
            S_CONV_TAP: begin
                tap_k_next  = tap_next;
                iaddr_next  = ADDR_W'(tap_iaddr);
                mac_en_next = tap_in_bounds;
            end
            S_CONV_WR: begin
                cwr_next      = 1'b1;
                csel_next     = CSEL_L0;
                caddr_wr_next = ADDR_W'({row_next, col_next});
                mac_clr_next  = 1'b1;
            end
            S_POOL_RD: begin
                // quad[1] selects the lower row of the 2x2 block, quad[0] the right column.
                crd_next      = 1'b1;
                csel_next     = CSEL_L0;
                caddr_rd_next = ADDR_W'({prow_next, quad_next[1], pcol_next, quad_next[0]});
                pool_en_next  = 1'b1;
                pool_ld_next  = (quad_next == 2'd0);
            end
            S_POOL_WR: begin
                cwr_next      = 1'b1;
                csel_next     = CSEL_L1;
                caddr_wr_next = ADDR_W'({prow_next, pcol_next});
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= S_IDLE;
            row_reg      <= '0;
            col_reg      <= '0;
            prow_reg     <= '0;
            pcol_reg     <= '0;
            tap_reg      <= '0;
            quad_reg     <= '0;
            busy_reg     <= 1'b0;
            iaddr_reg    <= '0;
            tap_k_reg    <= '0;
            mac_en_reg   <= 1'b0;
            mac_clr_reg  <= 1'b0;
            cwr_reg      <= 1'b0;
            caddr_wr_reg <= '0;
            crd_reg      <= 1'b0;
            caddr_rd_reg <= '0;
            pool_en_reg  <= 1'b0;
            pool_ld_reg  <= 1'b0;
            csel_reg     <= CSEL_NONE;
        end else begin
            state_reg    <= state_next;
            row_reg      <= row_next;
            col_reg      <= col_next;
            prow_reg     <= prow_next;
            pcol_reg     <= pcol_next;
            tap_reg      <= tap_next;
            quad_reg     <= quad_next;
            busy_reg     <= busy_next;
            iaddr_reg    <= iaddr_next;
            tap_k_reg    <= tap_k_next;
            mac_en_reg   <= mac_en_next;
            mac_clr_reg  <= mac_clr_next;
            cwr_reg      <= cwr_next;
            caddr_wr_reg <= caddr_wr_next;
            crd_reg      <= crd_next;
            caddr_rd_reg <= caddr_rd_next;
            pool_en_reg  <= pool_en_next;
            pool_ld_reg  <= pool_ld_next;
            csel_reg     <= csel_next;
        end
    end

    assign bus.busy     = busy_reg;
    assign bus.iaddr    = iaddr_reg;
    assign bus.tap_k    = tap_k_reg;
    assign bus.mac_en   = mac_en_reg;
    assign bus.mac_clr  = mac_clr_reg;
    assign bus.cwr      = cwr_reg;
    assign bus.caddr_wr = caddr_wr_reg;
    assign bus.crd      = crd_reg;
    assign bus.caddr_rd = caddr_rd_reg;
    assign bus.pool_en  = pool_en_reg;
    assign bus.pool_ld  = pool_ld_reg;
    assign bus.csel     = csel_reg;

endmodule

// File: tb/tb_conv_ctrl.sv
// Bench for conv_ctrl: behavioural datapath driven by the strobes, compared against golden conv/pool.
module tb_conv_ctrl;
    import conv_ctrl_pkg::*;

    localparam int N  = 64;
    localparam int NP = 32;
    localparam int AW = 12;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    conv_ctrl_if #(.ADDR_W(AW)) bus ();

    conv_ctrl #(.IMG_LOG2(6), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    int img [N*N];
    int w [9];
    int bias;
    int l0_g [N*N];
    int l1_g [NP*NP];
    int l0_m [N*N];
    int l1_m [NP*NP];

    function automatic int tap_in(int r, int c, int k);
        int rr = r + k / 3 - 1;
        int cc = c + k % 3 - 1;
        return (rr >= 0 && rr < N && cc >= 0 && cc < N) ? 1 : 0;
    endfunction

    function automatic int tap_ia(int r, int c, int k);
        return (tap_in(r, c, k) != 0) ? (r + k / 3 - 1) * N + (c + k % 3 - 1) : 0;
    endfunction

    function automatic int exp_pat(int r, int c);
        int p = 0;
        for (int k = 0; k < 9; k++) p = p * 2 + tap_in(r, c, k);
        return p;
    endfunction

    // Datapath model state and per-pixel / per-block observation buffers
    longint acc;
    int pmax, cd;
    int nt, npr, n_l0, n_l1;
    int tk [9];
    int me [9];
    int ia [9];
    int pa [4];
    int pe [4];
    int pl [4];
    int tap_err, pool_err, viol;
    int p, r, c, q, pr, pc, pat, v;

    always @(posedge clk or negedge reset) begin : dp_model
        if (!reset) begin
            acc = 0; pmax = 0; nt = 0; npr = 0; n_l0 = 0; n_l1 = 0;
        end else begin
            if (bus.cwr && bus.crd) viol++;
            if (!bus.cwr && !bus.crd && bus.csel != CSEL_NONE) viol++;
            if (bus.cwr && bus.csel != CSEL_L0 && bus.csel != CSEL_L1) viol++;

            if (bus.busy && !bus.cwr && !bus.crd && n_l0 < N*N) begin
                if (nt < 9) begin
                    tk[nt] = int'(bus.tap_k); me[nt] = int'(bus.mac_en); ia[nt] = int'(bus.iaddr);
                end
                nt++;
            end

            if (bus.cwr && bus.csel == CSEL_L0) begin
                if (n_l0 < N*N) begin
                    p = n_l0; r = p / N; c = p % N;
                    if (int'(bus.caddr_wr) != p || nt != 9) tap_err++;
                    pat = 0;
                    for (int k = 0; k < 9; k++) begin
                        if (nt == 9) begin
                            if (tk[k] != k || me[k] != tap_in(r, c, k) || ia[k] != tap_ia(r, c, k)) tap_err++;
                            pat = pat * 2 + me[k];
                        end
                    end
                    if (p == 0) begin
                        chk("first_l0_caddr_wr", bus.caddr_wr, 0);
                        chk("mac_pat_0_0", pat, 9'b000011011);
                    end
                    if (p == 5)       chk("mac_pat_0_5", pat, exp_pat(0, 5));
                    if (p == N*N - 1) chk("mac_pat_63_63", pat, exp_pat(63, 63));
                    if (p == 10*N + 10) chk("iaddr_10_10_tap0", ia[0], 585);
                end
                v = int'(acc) + bias;
                l0_m[bus.caddr_wr] = (v < 0) ? 0 : v;
                n_l0++;
                nt = 0;
            end

            if (bus.crd) begin
                cd = l0_m[bus.caddr_rd];
                if (npr < 4) begin
                    pa[npr] = int'(bus.caddr_rd); pe[npr] = int'(bus.pool_en); pl[npr] = int'(bus.pool_ld);
                end
                npr++;
                if (bus.pool_en) pmax = bus.pool_ld ? cd : ((cd > pmax) ? cd : pmax);
            end

            if (bus.cwr && bus.csel == CSEL_L1) begin
                if (n_l1 < NP*NP) begin
                    q = n_l1; pr = q / NP; pc = q % NP;
                    if (int'(bus.caddr_wr) != q || npr != 4) pool_err++;
                    for (int j = 0; j < 4; j++) begin
                        if (npr == 4 && (pa[j] != (2*pr + j/2) * N + 2*pc + j%2 ||
                                         pe[j] != 1 || pl[j] != ((j == 0) ? 1 : 0))) pool_err++;
                    end
                    if (q == 1*NP + 2) begin
                        chk("pool12_rd0", pa[0], 132);
                        chk("pool12_rd1", pa[1], 133);
                        chk("pool12_rd2", pa[2], 196);
                        chk("pool12_rd3", pa[3], 197);
                        chk("pool12_ld_bits", pl[0]*8 + pl[1]*4 + pl[2]*2 + pl[3], 8);
                        chk("pool12_caddr_wr", bus.caddr_wr, 34);
                        chk("pool12_csel", bus.csel, 3);
                    end
                end
                l1_m[bus.caddr_wr[9:0]] = pmax;
                n_l1++;
                npr = 0;
            end

            if (bus.mac_clr) acc = 0;
            else if (bus.mac_en && bus.tap_k < 9) acc += longint'(img[bus.iaddr]) * w[bus.tap_k];
        end
    end

    int cyc, busy_cyc, e0, e1, s, m;

    initial begin
        bus.ready = 1'b0;
        tap_err = 0; pool_err = 0; viol = 0;
        for (int i = 0; i < N*N; i++) img[i] = int'($urandom_range(0, 255));
        for (int k = 0; k < 9; k++) w[k] = int'($urandom_range(0, 15)) - 8;
        bias = int'($urandom_range(0, 400)) - 200;
        for (int rr = 0; rr < N; rr++)
            for (int cc = 0; cc < N; cc++) begin
                s = bias;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if (rr+dy >= 0 && rr+dy < N && cc+dx >= 0 && cc+dx < N)
                            s += img[(rr+dy)*N + cc+dx] * w[(dy+1)*3 + dx+1];
                l0_g[rr*N + cc] = (s < 0) ? 0 : s;
            end
        for (int a = 0; a < NP; a++)
            for (int b = 0; b < NP; b++) begin
                m = l0_g[2*a*N + 2*b];
                for (int j = 1; j < 4; j++)
                    if (l0_g[(2*a + j/2)*N + 2*b + j%2] > m) m = l0_g[(2*a + j/2)*N + 2*b + j%2];
                l1_g[a*NP + b] = m;
            end

        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_strobes", {bus.mac_en, bus.mac_clr, bus.cwr, bus.crd, bus.pool_en, bus.pool_ld}, 0);
        chk("rst_csel", bus.csel, 0);
        chk("rst_iaddr", bus.iaddr, 0);
        chk("rst_caddr", {bus.caddr_wr, bus.caddr_rd}, 0);
        chk("rst_tap_k", bus.tap_k, 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", bus.busy, 0);

        // Short run, then asynchronous reset in the middle of an in-bounds tap
        bus.ready = 1'b1;
        @(negedge clk);
        bus.ready = 1'b0;
        chk("busy_next_cycle", bus.busy, 1);
        repeat (200) @(negedge clk);
        cyc = 0;
        while (!(bus.mac_en && !bus.cwr) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("find_tap_in_time", (cyc < 100) ? 1 : 0, 1);
        #2 reset = 1'b0;
        #1;
        chk("arst_busy", bus.busy, 0);
        chk("arst_mac_en", bus.mac_en, 0);
        chk("arst_cwr", bus.cwr, 0);
        chk("arst_csel", bus.csel, 0);
        chk("arst_iaddr", bus.iaddr, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        chk("no_restart_without_ready", bus.busy, 0);

        // Full run; ready toggles randomly while busy, then stays high into the next IDLE
        bus.ready = 1'b1;
        @(negedge clk);
        busy_cyc = 0;
        cyc = 0;
        while (bus.busy && cyc < 50000) begin
            busy_cyc++;
            cyc++;
            bus.ready = (busy_cyc < 40000) ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge clk);
        end
        chk("busy_cycles", busy_cyc, 46081);
        chk("l0_writes", n_l0, N*N);
        chk("l1_writes", n_l1, NP*NP);
        e0 = 0;
        e1 = 0;
        for (int i = 0; i < N*N; i++)   if (l0_m[i] != l0_g[i]) e0++;
        for (int i = 0; i < NP*NP; i++) if (l1_m[i] != l1_g[i]) e1++;
        chk("l0_mem_errs", e0, 0);
        chk("l1_mem_errs", e1, 0);
        chk("tap_seq_errs", tap_err, 0);
        chk("pool_seq_errs", pool_err, 0);
        chk("strobe_viol", viol, 0);
        @(negedge clk);
        chk("rerun_after_one_idle", bus.busy, 1);

        bus.ready = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
